// File: rtl/alu_ctl_seq.sv
// ALU control unit: registered ALUOp/Funct decode plus an iterative multu/divu
// sequencer with busy/stall, HiLo write pulse and kill.
module alu_ctl_seq #(
    parameter int unsigned FUNCT_W    = 6,
    parameter int unsigned MUL_CYCLES = 32,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned F_MULTU    = 25,
    parameter int unsigned F_DIVU     = 27,
    parameter logic [FUNCT_W-1:0] HILO_OP = FUNCT_W'(6'h3F),
    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES,
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic               kill,
    input  logic [1:0]         ALUOp,
    input  logic [FUNCT_W-1:0] Funct,
    output logic [FUNCT_W-1:0] op_out,
    output logic               busy,
    output logic               stall,
    output logic               hilo_we,
    output logic [CNT_W-1:0]   iter
);

    localparam logic [FUNCT_W-1:0] OP_NOP   = '0;
    localparam logic [FUNCT_W-1:0] OP_ADD   = FUNCT_W'(32);
    localparam logic [FUNCT_W-1:0] OP_SUB   = FUNCT_W'(34);
    localparam logic [FUNCT_W-1:0] OP_MULTU = FUNCT_W'(F_MULTU);
    localparam logic [FUNCT_W-1:0] OP_DIVU  = FUNCT_W'(F_DIVU);
    localparam logic [CNT_W-1:0]   MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DIV_LAST = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [FUNCT_W-1:0] op_d;
    logic               busy_d;
    logic               hilo_we_d;
    logic [CNT_W-1:0]   iter_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_out  <= '0;
            busy    <= 1'b0;
            stall   <= 1'b0;
            hilo_we <= 1'b0;
            iter    <= '0;
        end else begin
            state_q <= state_d;
            op_out  <= op_d;
            busy    <= busy_d;
            stall   <= busy_d;
            hilo_we <= hilo_we_d;
            iter    <= iter_d;
        end
    end

    // Next state and next output values; DONE decodes like IDLE so ops can chain
    always_comb begin
        state_d   = state_q;
        op_d      = OP_NOP;
        hilo_we_d = 1'b0;
        iter_d    = '0;

        if (kill) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (valid_in) begin
                        unique case (ALUOp)
                            2'b00: op_d = OP_ADD;
                            2'b01: op_d = OP_SUB;
                            2'b10: begin
                                op_d = Funct;
                                if (Funct == OP_MULTU) begin
                                    state_d = MUL;
                                end else if (Funct == OP_DIVU) begin
                                    state_d = DIV;
                                end
                            end
                            default: op_d = OP_NOP;
                        endcase
                    end
                end
                MUL: begin
                    if (iter == MUL_LAST) begin
                        state_d   = DONE;
                        op_d      = HILO_OP;
                        hilo_we_d = 1'b1;
                    end else begin
                        op_d   = OP_MULTU;
                        iter_d = iter + CNT_W'(1);
                    end
                end
                DIV: begin
                    if (iter == DIV_LAST) begin
                        state_d   = DONE;
                        op_d      = HILO_OP;
                        hilo_we_d = 1'b1;
                    end else begin
                        op_d   = OP_DIVU;
                        iter_d = iter + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy_d = (state_d != IDLE);

endmodule

// File: tb/tb_alu_ctl_seq.sv
// Bench for alu_ctl_seq: three parameterisations driven in lockstep, checked
// every cycle against a schedule-based model plus hand-computed literals.
module tb_alu_ctl_seq;

    localparam int NI = 3;
    // instance 0: defaults, 1: DIV_CYCLES=4, 2: MUL_CYCLES=1
    localparam int MUL_LEN [NI] = '{32, 32, 1};
    localparam int DIV_LEN [NI] = '{32, 4, 32};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic       kill = 1'b0;
    logic [1:0] alu_op = 2'b11;
    logic [5:0] funct = '0;

    logic [5:0] op_o    [NI];
    logic       busy_o  [NI];
    logic       stall_o [NI];
    logic       we_o    [NI];
    logic [5:0] iter_o  [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_ctl_seq u_def (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .kill(kill),
        .ALUOp(alu_op), .Funct(funct), .op_out(op_o[0]), .busy(busy_o[0]),
        .stall(stall_o[0]), .hilo_we(we_o[0]), .iter(iter_o[0])
    );

    alu_ctl_seq #(.DIV_CYCLES(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .kill(kill),
        .ALUOp(alu_op), .Funct(funct), .op_out(op_o[1]), .busy(busy_o[1]),
        .stall(stall_o[1]), .hilo_we(we_o[1]), .iter(iter_o[1])
    );

    alu_ctl_seq #(.MUL_CYCLES(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .kill(kill),
        .ALUOp(alu_op), .Funct(funct), .op_out(op_o[2]), .busy(busy_o[2]),
        .stall(stall_o[2]), .hilo_we(we_o[2]), .iter(iter_o[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted multu/divu owns the outputs for a fixed schedule of
    // len iteration cycles followed by one HiLo-write cycle; otherwise decode.
    bit active [NI];
    int pos    [NI];
    int len    [NI];
    int code   [NI];
    int e_op   [NI];
    int e_busy [NI];
    int e_we   [NI];
    int e_iter [NI];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n || kill) begin
                active[i] = 1'b0;
                e_op[i] = 0; e_busy[i] = 0; e_we[i] = 0; e_iter[i] = 0;
            end else begin
                if (active[i] && pos[i] < len[i]) begin
                    pos[i]++;
                end else begin
                    active[i] = 1'b0;
                    if (!valid_in)           e_op[i] = 0;
                    else if (alu_op == 2'd0) e_op[i] = 32;
                    else if (alu_op == 2'd1) e_op[i] = 34;
                    else if (alu_op == 2'd3) e_op[i] = 0;
                    else                     e_op[i] = int'(funct);
                    if (valid_in && alu_op == 2'd2 && (funct == 6'd25 || funct == 6'd27)) begin
                        active[i] = 1'b1;
                        pos[i]    = 0;
                        code[i]   = int'(funct);
                        len[i]    = (funct == 6'd25) ? MUL_LEN[i] : DIV_LEN[i];
                    end
                end
                if (!active[i]) begin
                    e_busy[i] = 0; e_we[i] = 0; e_iter[i] = 0;
                end else if (pos[i] < len[i]) begin
                    e_op[i] = code[i]; e_busy[i] = 1; e_we[i] = 0; e_iter[i] = pos[i];
                end else begin
                    e_op[i] = 63; e_busy[i] = 1; e_we[i] = 1; e_iter[i] = 0;
                end
            end
        end
    end

    int we_cnt   [NI] = '{0, 0, 0};
    int busy_cnt [NI] = '{0, 0, 0};

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("op_out[%0d]", i),  int'(op_o[i]),   e_op[i]);
            chk($sformatf("busy[%0d]", i),    int'(busy_o[i]), e_busy[i]);
            chk($sformatf("stall[%0d]", i),   int'(stall_o[i]), e_busy[i]);
            chk($sformatf("hilo_we[%0d]", i), int'(we_o[i]),   e_we[i]);
            chk($sformatf("iter[%0d]", i),    int'(iter_o[i]), e_iter[i]);
            we_cnt[i]   += int'(we_o[i]);
            busy_cnt[i] += int'(busy_o[i]);
        end
    end

    task automatic step(input logic v, input logic [1:0] a, input logic [5:0] f, input logic k);
        valid_in = v; alu_op = a; funct = f; kill = k;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 2'b11, 6'd0, 1'b0);
    endtask

    initial begin
        // reset and release
        repeat (2) @(posedge clk);
        #1;
        chk("reset_op", int'(op_o[0]), 0);
        chk("reset_busy", int'(busy_o[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // plain decode, one cycle latency
        step(1'b1, 2'b00, 6'd0, 1'b0);  chk("dec_add", int'(op_o[0]), 32);
        step(1'b1, 2'b01, 6'd0, 1'b0);  chk("dec_sub", int'(op_o[0]), 34);
        step(1'b1, 2'b10, 6'd37, 1'b0); chk("dec_funct", int'(op_o[0]), 37);
        step(1'b1, 2'b11, 6'd37, 1'b0); chk("dec_nop", int'(op_o[0]), 0);
        step(1'b0, 2'b00, 6'd0, 1'b0);  chk("dec_invalid", int'(op_o[0]), 0);

        // multu with default length
        busy_cnt[0] = 0;
        we_cnt[0] = 0;
        step(1'b1, 2'b10, 6'd25, 1'b0);
        chk("mul_start_op", int'(op_o[0]), 25);
        chk("mul_start_busy", int'(busy_o[0]), 1);
        chk("mul_start_iter", int'(iter_o[0]), 0);
        idle(31);
        chk("mul_last_iter", int'(iter_o[0]), 31);
        chk("mul_last_op", int'(op_o[0]), 25);
        idle(1);
        chk("mul_done_op", int'(op_o[0]), 63);
        chk("mul_done_we", int'(we_o[0]), 1);
        idle(1);
        chk("mul_end_busy", int'(busy_o[0]), 0);
        chk("mul_busy_cycles", busy_cnt[0], 33);
        chk("mul_we_pulses", we_cnt[0], 1);
        idle(2);

        // kill mid-sequence, then kill together with a start
        step(1'b1, 2'b10, 6'd25, 1'b0);
        idle(5);
        chk("kill_pre_iter", int'(iter_o[0]), 5);
        step(1'b0, 2'b11, 6'd0, 1'b1);
        chk("kill_op", int'(op_o[0]), 0);
        chk("kill_busy", int'(busy_o[0]), 0);
        chk("kill_we", int'(we_o[0]), 0);
        step(1'b1, 2'b10, 6'd25, 1'b1);
        chk("kill_start_busy", int'(busy_o[0]), 0);
        chk("kill_start_op", int'(op_o[0]), 0);
        idle(2);

        // divu with DIV_CYCLES=4 chained straight into multu
        we_cnt[1] = 0;
        step(1'b1, 2'b10, 6'd27, 1'b0);
        chk("div4_start_op", int'(op_o[1]), 27);
        idle(3);
        chk("div4_last_iter", int'(iter_o[1]), 3);
        idle(1);
        chk("div4_done_op", int'(op_o[1]), 63);
        chk("div4_done_we", int'(we_o[1]), 1);
        step(1'b1, 2'b10, 6'd25, 1'b0);
        chk("chain_mul_op", int'(op_o[1]), 25);
        chk("chain_mul_busy", int'(busy_o[1]), 1);
        chk("chain_mul_iter", int'(iter_o[1]), 0);
        idle(40);
        chk("chain_we_pulses", we_cnt[1], 2);

        // MUL_CYCLES=1
        busy_cnt[2] = 0;
        step(1'b1, 2'b10, 6'd25, 1'b0);
        chk("m1_op", int'(op_o[2]), 25);
        chk("m1_we0", int'(we_o[2]), 0);
        idle(1);
        chk("m1_done_op", int'(op_o[2]), 63);
        chk("m1_done_we", int'(we_o[2]), 1);
        idle(1);
        chk("m1_busy_cycles", busy_cnt[2], 2);
        idle(40);

        // asynchronous reset in the middle of a multu
        we_cnt[0] = 0;
        step(1'b1, 2'b10, 6'd25, 1'b0);
        idle(10);
        chk("rst_pre_iter", int'(iter_o[0]), 10);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_op", int'(op_o[0]), 0);
        chk("arst_busy", int'(busy_o[0]), 0);
        chk("arst_stall", int'(stall_o[0]), 0);
        chk("arst_iter", int'(iter_o[0]), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 2'b00, 6'd0, 1'b0);
        chk("post_rst_add", int'(op_o[0]), 32);
        idle(40);
        chk("post_rst_no_we", we_cnt[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
